// File: rtl/alu_input_sequencer_pkg.sv
// Shared definitions for the ALU front-end: opcode values, FSM state encoding
// and the opcode legality check used before starting the ALU.
package alu_input_sequencer_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_input_sequencer_btn_debounce.sv
// One raw push button -> synchronised, debounced level -> single-cycle pulse on
// each accepted press. A held button produces exactly one pulse.
module alu_input_sequencer_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic             deb_d;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; sync1->sync2 only forms a real 2-FF chain this way.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      cnt     <= '0;
      o_pulse <= 1'b0;
    end else begin
      sync1   <= i_btn;
      sync2   <= sync1;
      deb_d   <= deb;
      o_pulse <= deb & ~deb_d;
      // Any sample agreeing with the accepted level restarts the stability count.
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= ~deb;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_input_sequencer.sv
// Board-side controller for the ALU: loads A, B and the opcode from the switches
// on debounced button presses, pulses the ALU start and latches its result.
module alu_input_sequencer
  import alu_input_sequencer_pkg::*;
#(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = OP_W,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  input  logic [NB_DATA:0]   i_alu_result,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic               o_alu_start,
  output logic [NB_DATA:0]   o_led,
  output logic [2:0]         o_state,
  output logic               o_err
);

  logic   pulse_a;
  logic   pulse_b;
  logic   pulse_op;
  state_t state;
  state_t state_next;
  logic   op_legal;
  logic   load_a;
  logic   load_b;
  logic   op_try;
  logic   load_led;
  logic   clr_err;

  alu_input_sequencer_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_btn   (i_btn_a),
    .o_pulse (pulse_a)
  );

  alu_input_sequencer_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_btn   (i_btn_b),
    .o_pulse (pulse_b)
  );

  alu_input_sequencer_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_op (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_btn   (i_btn_op),
    .o_pulse (pulse_op)
  );

  assign op_legal = is_legal_op(i_sw[NB_OP-1:0]);

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= S_LOAD_A;
    else         state <= state_next;
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_LOAD_A:  if (pulse_a)              state_next = S_LOAD_B;
      S_LOAD_B:  if (pulse_b)              state_next = S_LOAD_OP;
      S_LOAD_OP: if (pulse_op && op_legal) state_next = S_EXEC;
      S_EXEC:                              state_next = S_SHOW;
      S_SHOW:    if (pulse_a)              state_next = S_LOAD_B;
      default:                             state_next = S_LOAD_A;
    endcase
  end

  // Pulses that do not belong to the current state are simply not used here,
  // so they are dropped rather than queued. B wins over a reload of A.
  always_comb begin
    load_a      = 1'b0;
    load_b      = 1'b0;
    op_try      = 1'b0;
    load_led    = 1'b0;
    clr_err     = 1'b0;
    o_alu_start = 1'b0;
    case (state)
      S_LOAD_A:  load_a = pulse_a;
      S_LOAD_B: begin
        load_b = pulse_b;
        load_a = pulse_a & ~pulse_b;
      end
      S_LOAD_OP: op_try = pulse_op;
      S_EXEC: begin
        o_alu_start = 1'b1;
        load_led    = 1'b1;
      end
      S_SHOW: begin
        load_a  = pulse_a;
        clr_err = pulse_a;
      end
      default: ;
    endcase
  end

  assign o_state = state;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_data_a <= '0;
      o_data_b <= '0;
      o_op     <= '0;
      o_led    <= '0;
      o_err    <= 1'b0;
    end else begin
      if (load_a)   o_data_a <= i_sw;
      if (load_b)   o_data_b <= i_sw;
      if (load_led) o_led    <= i_alu_result;
      if (op_try) begin
        o_err <= ~op_legal;
        if (op_legal) o_op <= i_sw[NB_OP-1:0];
      end else if (clr_err) begin
        o_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer: a behavioural model (sample windows for
// the buttons, a plain sequencing model for the loads) checked every cycle.
module tb_alu_input_sequencer;

  localparam int DC = 4;

  localparam int M_LOAD_A  = 0;
  localparam int M_LOAD_B  = 1;
  localparam int M_LOAD_OP = 2;
  localparam int M_EXEC    = 3;
  localparam int M_SHOW    = 4;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic [7:0] i_sw = '0;
  logic       i_btn_a = 1'b0;
  logic       i_btn_b = 1'b0;
  logic       i_btn_op = 1'b0;
  logic [8:0] i_alu_result;
  logic [7:0] o_data_a;
  logic [7:0] o_data_b;
  logic [5:0] o_op;
  logic       o_alu_start;
  logic [8:0] o_led;
  logic [2:0] o_state;
  logic       o_err;

  int n_tests = 0;
  int n_fail  = 0;
  int starts  = 0;
  bit cmp_en  = 0;

  logic [5:0] legal_ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b100110, 6'b100111, 6'b000011, 6'b000010};

  always #5 clk = ~clk;

  alu_input_sequencer #(.NB_DATA(8), .NB_OP(6), .DEBOUNCE_CYCLES(DC)) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_sw         (i_sw),
    .i_btn_a      (i_btn_a),
    .i_btn_b      (i_btn_b),
    .i_btn_op     (i_btn_op),
    .i_alu_result (i_alu_result),
    .o_data_a     (o_data_a),
    .o_data_b     (o_data_b),
    .o_op         (o_op),
    .o_alu_start  (o_alu_start),
    .o_led        (o_led),
    .o_state      (o_state),
    .o_err        (o_err)
  );

  function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input logic [5:0] op);
    if (op == ADD) return {1'b0, a} + {1'b0, b};
    if (op == SUB) return {1'b0, a} - {1'b0, b};
    return 9'd0;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  assign i_alu_result = alu(o_data_a, o_data_b, o_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state
  int         m_state;
  logic [7:0] m_a, m_b;
  logic [5:0] m_op;
  logic [8:0] m_led;
  bit         m_err;
  bit         m_h0[3], m_h1[3];
  bit         m_win[3][DC];
  bit         m_deb[3], m_rose[3], m_pulse[3];

  always @(posedge clk) begin
    bit raw[3];
    bit delayed, all_diff, pa, pb, po;
    raw = '{i_btn_a, i_btn_b, i_btn_op};
    if (i_reset) begin
      m_state = M_LOAD_A; m_a = '0; m_b = '0; m_op = '0; m_led = '0; m_err = 0;
      for (int i = 0; i < 3; i++) begin
        m_h0[i] = 0; m_h1[i] = 0; m_deb[i] = 0; m_rose[i] = 0; m_pulse[i] = 0;
        for (int k = 0; k < DC; k++) m_win[i][k] = 0;
      end
    end else begin
      pa = m_pulse[0]; pb = m_pulse[1]; po = m_pulse[2];
      case (m_state)
        M_LOAD_A: if (pa) begin m_a = i_sw; m_state = M_LOAD_B; end
        M_LOAD_B: begin
          if (pb) begin m_b = i_sw; m_state = M_LOAD_OP; end
          else if (pa) m_a = i_sw;
        end
        M_LOAD_OP: if (po) begin
          if (legal(i_sw[5:0])) begin m_op = i_sw[5:0]; m_err = 0; m_state = M_EXEC; end
          else m_err = 1;
        end
        M_EXEC: begin m_led = alu(m_a, m_b, m_op); m_state = M_SHOW; end
        default: if (pa) begin m_a = i_sw; m_err = 0; m_state = M_LOAD_B; end
      endcase
      // A level is accepted once the last DC synchronised samples all disagree
      // with the current accepted level; the press pulse follows one cycle later.
      for (int i = 0; i < 3; i++) begin
        delayed = m_h1[i];
        m_h1[i] = m_h0[i];
        m_h0[i] = raw[i];
        for (int k = DC - 1; k > 0; k--) m_win[i][k] = m_win[i][k-1];
        m_win[i][0] = delayed;
        all_diff = 1;
        for (int k = 0; k < DC; k++) if (m_win[i][k] == m_deb[i]) all_diff = 0;
        m_pulse[i] = m_rose[i];
        m_rose[i]  = all_diff && !m_deb[i];
        if (all_diff) m_deb[i] = !m_deb[i];
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("state", 32'(o_state), 32'(m_state));
      check("data_a", 32'(o_data_a), 32'(m_a));
      check("data_b", 32'(o_data_b), 32'(m_b));
      check("op", 32'(o_op), 32'(m_op));
      check("led", 32'(o_led), 32'(m_led));
      check("err", 32'(o_err), 32'(m_err));
      check("alu_start", 32'(o_alu_start), 32'(m_state == M_EXEC));
      if (o_alu_start) starts++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // btns = {op, b, a}
  task automatic press(input logic [2:0] btns, input logic [7:0] sw, input int hold);
    i_sw = sw;
    {i_btn_op, i_btn_b, i_btn_a} = btns;
    step(hold);
    {i_btn_op, i_btn_b, i_btn_a} = 3'b000;
    step(16);
  endtask

  initial begin
    step(1);
    i_reset = 1'b1;
    step(1);
    cmp_en = 1;
    step(1);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_a", 32'(o_data_a), 32'd0);
    check("rst_led", 32'(o_led), 32'd0);
    check("rst_start_err", 32'({o_alu_start, o_err, o_op, o_data_b}), 32'd0);
    i_reset = 1'b0;
    step(1);

    // Bounce then a long hold on A
    press(3'b001, 8'hFF, 2);
    check("bounce_state", 32'(o_state), 32'd0);
    check("bounce_a", 32'(o_data_a), 32'd0);
    press(3'b001, 8'hFF, 50);
    check("held_a", 32'(o_data_a), 32'hFF);
    check("held_state", 32'(o_state), 32'd1);

    starts = 0;
    press(3'b010, 8'h01, 8);
    press(3'b100, {2'b00, ADD}, 8);
    check("add_b", 32'(o_data_b), 32'h01);
    check("add_op", 32'(o_op), 32'(6'b100000));
    check("add_led", 32'(o_led), 32'h100);
    check("add_state", 32'(o_state), 32'd4);
    check("add_starts", 32'(starts), 32'd1);

    // Illegal opcode then SUB
    press(3'b001, 8'hFF, 8);
    press(3'b010, 8'h01, 8);
    press(3'b100, 8'h3F, 8);
    check("ill_err", 32'(o_err), 32'd1);
    check("ill_state", 32'(o_state), 32'd2);
    check("ill_op", 32'(o_op), 32'(6'b100000));
    press(3'b100, {2'b00, SUB}, 8);
    check("sub_err", 32'(o_err), 32'd0);
    check("sub_led", 32'(o_led), 32'h0FE);

    // Reset in the middle of a sequence
    press(3'b001, 8'h10, 8);
    press(3'b010, 8'h20, 8);
    check("pre_rst_state", 32'(o_state), 32'd2);
    i_reset = 1'b1;
    step(1);
    i_reset = 1'b0;
    step(1);
    check("mid_rst_state", 32'(o_state), 32'd0);
    check("mid_rst_ab", 32'({o_data_a, o_data_b}), 32'd0);
    check("mid_rst_led", 32'(o_led), 32'd0);

    // B alone ignored, then A+B together loads A only
    press(3'b010, 8'h77, 8);
    check("b_alone_state", 32'(o_state), 32'd0);
    check("b_alone_b", 32'(o_data_b), 32'd0);
    press(3'b011, 8'h5A, 8);
    check("ab_a", 32'(o_data_a), 32'h5A);
    check("ab_b", 32'(o_data_b), 32'd0);
    check("ab_state", 32'(o_state), 32'd1);

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
